// File: rtl/regression_scheduler_pkg.sv
// Shared types and default sizing for the least-squares regression sequencer.
// The state enum is the single source of truth for the scheduler's phase order.
package regression_scheduler_pkg;

    localparam int DEFAULT_N_SAMPLES = 150;
    localparam int DEFAULT_ADDR_W    = 8;
    localparam int DEFAULT_DATA_W    = 20;

    typedef enum logic [3:0] {
        IDLE,
        CLR,
        MEAN,
        MX,
        MY,
        TEMP,
        B1,
        B0,
        ERR,
        DRAIN
    } state_t;

endpackage

// File: rtl/regression_scheduler_sample_counter.sv
// Sample address counter shared by the mean, temp and error passes.
// Wraps to zero on an explicit compare against the last index, not on overflow.
module regression_scheduler_sample_counter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_init,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_last,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_tc
);

    logic [ADDR_W-1:0] r_addr;

    assign o_tc   = (r_addr == i_last);
    assign o_addr = r_addr;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || i_init) begin
            r_addr <= '0;
        end else if (i_en) begin
            r_addr <= o_tc ? '0 : r_addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/regression_scheduler.sv
// Sequencer for the least-squares regression datapath: clear, mean, temp and
// coefficient phases, then a streamed error pass with valid/ready backpressure.
module regression_scheduler
    import regression_scheduler_pkg::*;
#(
    parameter int N_SAMPLES = DEFAULT_N_SAMPLES,
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int DATA_W    = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              ready,
    output logic              done,
    output logic [ADDR_W-1:0] address,
    output logic              rst_means,
    output logic              rst_temps,
    output logic              rst_beta,
    output logic              mean_en,
    output logic              load_mean_x,
    output logic              load_mean_y,
    output logic              select_150,
    output logic              select_y,
    output logic              load_temps,
    output logic              load_beta1,
    output logic              load_beta0,
    output logic              error_en,
    input  logic [DATA_W-1:0] e_in,
    output logic              e_valid,
    output logic [DATA_W-1:0] e_data,
    output logic [ADDR_W-1:0] e_index,
    input  logic              e_ready
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);

    state_t            r_state;
    state_t            w_next_state;

    logic              r_e_valid;
    logic [DATA_W-1:0] r_e_data;
    logic [ADDR_W-1:0] r_e_index;
    logic              r_done;

    logic              w_accept;
    logic              w_capture;
    logic              w_cnt_init;
    logic              w_cnt_en;
    logic              w_cnt_tc;
    logic [ADDR_W-1:0] w_address;

    // A held word frees its slot in the same cycle it is accepted.
    assign w_accept   = r_e_valid && e_ready;
    assign w_capture  = (r_state == ERR) && (!r_e_valid || e_ready);
    assign w_cnt_init = (r_state == CLR);
    assign w_cnt_en   = (r_state == MEAN) || (r_state == TEMP) || w_capture;

    regression_scheduler_sample_counter #(
        .ADDR_W (ADDR_W)
    ) u_sample_counter (
        .clk    (clk),
        .rst    (rst),
        .i_init (w_cnt_init),
        .i_en   (w_cnt_en),
        .i_last (LAST_ADDR),
        .o_addr (w_address),
        .o_tc   (w_cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        ready        = 1'b0;
        rst_means    = 1'b0;
        rst_temps    = 1'b0;
        rst_beta     = 1'b0;
        mean_en      = 1'b0;
        load_mean_x  = 1'b0;
        load_mean_y  = 1'b0;
        select_150   = 1'b0;
        select_y     = 1'b0;
        load_temps   = 1'b0;
        load_beta1   = 1'b0;
        load_beta0   = 1'b0;
        error_en     = 1'b0;

        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_next_state = CLR;
                end
            end
            CLR: begin
                rst_means    = 1'b1;
                rst_temps    = 1'b1;
                rst_beta     = 1'b1;
                w_next_state = MEAN;
            end
            MEAN: begin
                mean_en = 1'b1;
                if (w_cnt_tc) begin
                    w_next_state = MX;
                end
            end
            MX: begin
                select_150   = 1'b1;
                load_mean_x  = 1'b1;
                w_next_state = MY;
            end
            MY: begin
                select_150   = 1'b1;
                select_y     = 1'b1;
                load_mean_y  = 1'b1;
                w_next_state = TEMP;
            end
            TEMP: begin
                load_temps = 1'b1;
                if (w_cnt_tc) begin
                    w_next_state = B1;
                end
            end
            B1: begin
                load_beta1   = 1'b1;
                w_next_state = B0;
            end
            B0: begin
                load_beta0   = 1'b1;
                w_next_state = ERR;
            end
            ERR: begin
                error_en = 1'b1;
                if (w_capture && w_cnt_tc) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                error_en = 1'b1;
                if (w_accept) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Output slot: captured words stay frozen until the consumer takes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_e_valid <= 1'b0;
            r_e_data  <= '0;
            r_e_index <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == DRAIN) && w_accept;
            if (w_capture) begin
                r_e_valid <= 1'b1;
                r_e_data  <= e_in;
                r_e_index <= w_address;
            end else if (w_accept) begin
                r_e_valid <= 1'b0;
            end
        end
    end

    assign address = w_address;
    assign e_valid = r_e_valid;
    assign e_data  = r_e_data;
    assign e_index = r_e_index;
    assign done    = r_done;

endmodule

// File: tb/tb_regression_scheduler.sv
// Self-checking bench for regression_scheduler with N_SAMPLES=4: a cycle-timeline
// model of the phase schedule plus a word-stream scoreboard for the error pass.
module tb_regression_scheduler;

    localparam int NS     = 4;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 20;

    localparam logic [11:0] C_NONE = 12'h000;
    localparam logic [11:0] C_CLR  = 12'hE00;
    localparam logic [11:0] C_MEAN = 12'h100;
    localparam logic [11:0] C_MX   = 12'h0A0;
    localparam logic [11:0] C_MY   = 12'h070;
    localparam logic [11:0] C_TEMP = 12'h008;
    localparam logic [11:0] C_B1   = 12'h004;
    localparam logic [11:0] C_B0   = 12'h002;
    localparam logic [11:0] C_ERR  = 12'h001;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              ready;
    logic              done;
    logic [ADDR_W-1:0] address;
    logic              rst_means, rst_temps, rst_beta;
    logic              mean_en, load_mean_x, load_mean_y;
    logic              select_150, select_y, load_temps;
    logic              load_beta1, load_beta0, error_en;
    logic [DATA_W-1:0] e_in;
    logic              e_valid;
    logic [DATA_W-1:0] e_data;
    logic [ADDR_W-1:0] e_index;
    logic              e_ready;

    logic [11:0]       strobes;

    regression_scheduler #(
        .N_SAMPLES (NS),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ready       (ready),
        .done        (done),
        .address     (address),
        .rst_means   (rst_means),
        .rst_temps   (rst_temps),
        .rst_beta    (rst_beta),
        .mean_en     (mean_en),
        .load_mean_x (load_mean_x),
        .load_mean_y (load_mean_y),
        .select_150  (select_150),
        .select_y    (select_y),
        .load_temps  (load_temps),
        .load_beta1  (load_beta1),
        .load_beta0  (load_beta0),
        .error_en    (error_en),
        .e_in        (e_in),
        .e_valid     (e_valid),
        .e_data      (e_data),
        .e_index     (e_index),
        .e_ready     (e_ready)
    );

    always #5 clk = ~clk;

    // The error checker returns address+100 for the sample currently addressed.
    assign e_in    = DATA_W'(address) + DATA_W'(100);
    assign strobes = {rst_means, rst_temps, rst_beta, mean_en, load_mean_x, load_mean_y,
                      select_150, select_y, load_temps, load_beta1, load_beta0, error_en};

    int n_tests = 0;
    int n_fail  = 0;

    int k       = 0;
    bit running = 1'b0;
    bit mon_en  = 1'b0;

    int acc, last_accept_k, first_valid_k, done_k;
    int mean_cnt, temps_cnt, done_cnt;
    int bp_addr, bp_data;
    bit prev_hold;
    logic [DATA_W-1:0] prev_data;
    logic [ADDR_W-1:0] prev_index;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, t=%0t)", name, act, exp, k, $time);
        end
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        case (mode)
            1:       return !(cyc >= 2*NS+7 && cyc <= 2*NS+9);
            2:       return cyc[0];
            default: return 1'b1;
        endcase
    endfunction

    // Reference timeline: cycle k counts from the first cycle after start is sampled.
    initial begin
        logic [11:0]       exp_ctrl;
        logic              exp_ready, exp_done, exp_valid;
        logic [ADDR_W-1:0] exp_addr;
        forever begin
            @(negedge clk);
            if (mon_en && !running) begin
                check("idle", {ready, done, e_valid, strobes, address},
                      {1'b1, 1'b0, 1'b0, C_NONE, ADDR_W'(0)});
            end else if (mon_en) begin
                if (k == 1) begin
                    acc = 0; last_accept_k = -1; first_valid_k = -1; done_k = -1;
                    mean_cnt = 0; temps_cnt = 0; done_cnt = 0; prev_hold = 1'b0;
                    bp_addr = -1; bp_data = -1;
                end
                exp_ctrl = C_NONE; exp_ready = 1'b0; exp_done = 1'b0;
                exp_valid = 1'b0; exp_addr = '0;
                if (last_accept_k >= 0 && k == last_accept_k + 1) begin
                    exp_ready = 1'b1;
                    exp_done  = 1'b1;
                end else if (k == 1) begin
                    exp_ctrl = C_CLR;
                end else if (k <= NS + 1) begin
                    exp_ctrl = C_MEAN;
                    exp_addr = ADDR_W'(k - 2);
                end else if (k == NS + 2) begin
                    exp_ctrl = C_MX;
                end else if (k == NS + 3) begin
                    exp_ctrl = C_MY;
                end else if (k <= 2*NS + 3) begin
                    exp_ctrl = C_TEMP;
                    exp_addr = ADDR_W'(k - NS - 4);
                end else if (k == 2*NS + 4) begin
                    exp_ctrl = C_B1;
                end else if (k == 2*NS + 5) begin
                    exp_ctrl = C_B0;
                end else begin
                    exp_ctrl  = C_ERR;
                    exp_valid = (k >= 2*NS + 7) && (acc < NS);
                    exp_addr  = ADDR_W'((acc + (exp_valid ? 1 : 0)) % NS);
                end
                check("ctrl", {ready, done, e_valid, strobes, address},
                      {exp_ready, exp_done, exp_valid, exp_ctrl, exp_addr});
                if (exp_valid && e_valid) begin
                    check("e_data", e_data, DATA_W'(100 + acc));
                    check("e_index", e_index, ADDR_W'(acc));
                end
                if (prev_hold) begin
                    check("hold_stable", {e_valid, e_data, e_index}, {1'b1, prev_data, prev_index});
                end
                if (e_valid && first_valid_k < 0) first_valid_k = k;
                if (mean_en) mean_cnt++;
                if (load_temps) temps_cnt++;
                if (done) begin
                    done_cnt++;
                    done_k = k;
                end
                if (k == 2*NS + 9) begin
                    bp_addr = int'(address);
                    bp_data = int'(e_data);
                end
                if (e_valid && e_ready) begin
                    acc++;
                    if (acc == NS) last_accept_k = k;
                end
                prev_hold  = e_valid && !e_ready;
                prev_data  = e_data;
                prev_index = e_index;
            end
        end
    end

    task automatic run_pass(input int mode, input int start_k, input int abort_k);
        start   = 1'b1;
        e_ready = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        k       = 1;
        running = 1'b1;
        e_ready = ready_for(mode, k);
        while (running) begin
            @(posedge clk); #1;
            start = 1'b0;
            rst   = 1'b0;
            k++;
            if (k - 1 == abort_k) begin
                running = 1'b0;
            end else if (done) begin
                @(negedge clk); #1;
                running = 1'b0;
            end else if (k > 200) begin
                check("pass_timeout", 64'(k), 64'(0));
                running = 1'b0;
            end else begin
                start   = (k == start_k);
                rst     = (k == abort_k);
                e_ready = ready_for(mode, k);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        e_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_ctrl", {ready, done, e_valid, strobes, address},
              {1'b1, 1'b0, 1'b0, C_NONE, ADDR_W'(0)});
        check("reset_e_data", e_data, 0);
        check("reset_e_index", e_index, 0);
        mon_en = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        run_pass(0, -1, -1);
        check("full_first_valid", first_valid_k, 15);
        check("full_done_cycle", done_k, 19);
        check("full_mean_cnt", mean_cnt, 4);
        check("full_temps_cnt", temps_cnt, 4);
        check("full_accepts", acc, 4);
        check("full_done_cnt", done_cnt, 1);

        run_pass(1, -1, -1);
        check("bp_addr_frozen", bp_addr, 1);
        check("bp_data_held", bp_data, 100);
        check("bp_accepts", acc, 4);
        check("bp_done_cycle", done_k, 22);

        run_pass(2, -1, -1);
        check("alt_accepts", acc, 4);
        check("alt_done_cycle", done_k, 22);

        run_pass(0, NS + 5, -1);
        check("start_temp_mean_cnt", mean_cnt, 4);
        check("start_temp_temps_cnt", temps_cnt, 4);
        check("start_temp_done_cnt", done_cnt, 1);
        check("start_temp_done_cycle", done_k, 19);
        repeat (5) @(posedge clk);
        #1;

        run_pass(0, -1, 2*NS + 8);
        check("abort_done_cnt", done_cnt, 0);
        repeat (4) @(posedge clk);
        #1;

        run_pass(0, -1, -1);
        check("rerun_first_valid", first_valid_k, 15);
        check("rerun_done_cycle", done_k, 19);
        check("rerun_accepts", acc, 4);
        check("rerun_done_cnt", done_cnt, 1);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regression_scheduler.md
Name: regression_scheduler

Overview:
- Sequencer for the least-squares regression datapath: sample counter, coefficient calculator, beta0/beta1 registers and error checker.
- Drives the sample address, then runs three passes over the sample set: mean accumulation, covariance/temp accumulation and error evaluation.
- Streams each per-sample error word to a downstream consumer over a valid/ready handshake, with backpressure.
- Has its own address counter. Sits beside the data loader and replaces the free-running counter plus controller pair when streamed error output is required.

Parameters:
- N_SAMPLES, 150, number of samples per pass (address range 0..N_SAMPLES-1); legal range 2..2^ADDR_W.
- ADDR_W, 8, width of the sample address.
- DATA_W, 20, width of the error word.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  start request, sampled only in IDLE
- ready  out  1  high in IDLE only
- done  out  1  one-cycle pulse when the final error word has been accepted
- address  out  ADDR_W  sample index to the data loader
- rst_means, rst_temps, rst_beta  out  1 each  clear pulses to the datapath
- mean_en  out  1  accumulate x and y sums
- load_mean_x, load_mean_y  out  1 each  latch the divided means
- select_150, select_y  out  1 each  divider and operand selects
- load_temps  out  1  accumulate the covariance/variance temps
- load_beta1, load_beta0  out  1 each  coefficient register loads
- error_en  out  1  enables the error checker
- e_in  in  DATA_W  error from the error checker for the current address
- e_valid  out  1  output word valid
- e_data  out  DATA_W  registered error word
- e_index  out  ADDR_W  sample index of e_data
- e_ready  in  1  consumer accepts the word when e_valid and e_ready are both high

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, ready=1, address=0, e_valid=0, e_data=0, e_index=0, done=0, all datapath controls 0.
- Reset mid-operation aborts the pass in the next cycle; no done pulse is generated.
- Control strobes are Moore outputs decoded from the state register.
- IDLE: ready=1. start=1 goes to CLR. start in any other state is ignored.
- CLR (1 cycle): rst_means=rst_temps=rst_beta=1, address reset to 0.
- MEAN (N_SAMPLES cycles): mean_en=1, address increments every cycle. At address N_SAMPLES-1, address wraps to 0 and the state goes to MX.
- MX (1 cycle): select_150=1, select_y=0, load_mean_x=1.
- MY (1 cycle): select_150=1, select_y=1, load_mean_y=1.
- TEMP (N_SAMPLES cycles): load_temps=1, address increments every cycle; wraps to 0 and goes to B1.
- B1 (1 cycle): load_beta1=1.
- B0 (1 cycle): load_beta0=1; then ERR.
- ERR: error_en=1.
  - Capture condition: (!e_valid || e_ready). When true, e_data<=e_in, e_index<=address, e_valid<=1, address increments.
  - When false, address and e_data hold (stall).
  - Capturing address N_SAMPLES-1 moves the state to DRAIN.
- DRAIN: error_en=1, no new capture.
  - When e_valid && e_ready: e_valid<=0, done=1 for one cycle, state goes to IDLE.
- e_valid is dropped only by an accept. e_data and e_index are stable while e_valid=1 and e_ready=0.
- Latency with e_ready held high:
  - start sampled at cycle 0; first e_valid at cycle 2N+7.
  - One word per cycle after that; done one cycle after the last e_valid is accepted.
- Arithmetic: address counter is ADDR_W bits with explicit compare against N_SAMPLES-1, no reliance on natural wrap. e_data is passed through unmodified.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, CLR, MEAN, MX, MY, TEMP, B1, B0, ERR, DRAIN);
  - defaults N_SAMPLES=150, ADDR_W=8, DATA_W=20.
- One natural sub-module: sample_counter. It takes init, en and last-value inputs, returns the address and a terminal-count flag, and is shared by the MEAN, TEMP and ERR passes.
- FSM and output register stay in regression_scheduler.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> ready=1, e_valid=0, address=0, all strobes 0. start=0 for 10 cycles -> no state change.
- Full run, N_SAMPLES=4, e_ready=1, e_in=address+100 -> mean_en high exactly 4 cycles, load_temps high exactly 4 cycles. e_data sequence is 100,101,102,103 with e_index 0..3. First e_valid at cycle 15; done pulse at cycle 19.
- Backpressure, N=4: e_ready low for 3 cycles after the first e_valid -> e_data=100 and e_index=0 held stable, address frozen at 1. No word lost or duplicated; total of 4 accepts.
- Alternating e_ready (1,0,1,0...), N=4 -> exactly 4 accepts, in order 100..103, done one cycle after the 4th accept.
- start asserted during TEMP -> ignored: strobe counts are unchanged and there is a single done pulse.
- rst asserted mid-ERR with e_valid=1 -> next cycle IDLE, ready=1, e_valid=0, no done. A following start runs a clean full pass.
